// File: rtl/bcd_updown_counter_pkg.sv
// Shared BCD definitions used by the counter and its digit-step slices.
//   BCD_W           : width of one BCD digit
//   BCD_MAX/BCD_ZERO: the two terminal digit values
//   bcd_digit_valid : 1 when a 4-bit value is a legal BCD digit (0..9)
package bcd_pkg;

  localparam int         BCD_W    = 4;
  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  function automatic logic bcd_digit_valid(input logic [3:0] digit);
    return (digit <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_updown_counter_if.sv
// Command/status bundle of the BCD up/down counter.
//   clear, load, load_val, en, up : commands, driven by the master
//   count, tc, load_err           : registered status, driven by the slave
//
// Command semantics: there is no valid/ready handshake. Every command is
// sampled on every rising clk edge and is always accepted in that cycle;
// priority on one edge is clear > load > en, and any lower-priority command
// presented on the same edge is dropped, never deferred. Status outputs
// reflect the result of the previous edge.
interface bcd_updown_counter_if #(
  parameter int DIGITS = 4
) ();
  import bcd_pkg::*;

  logic                      clear;
  logic                      load;
  logic [BCD_W*DIGITS-1:0]   load_val;
  logic                      en;
  logic                      up;
  logic [BCD_W*DIGITS-1:0]   count;
  logic                      tc;
  logic                      load_err;

  modport master (
    output clear, load, load_val, en, up,
    input  count, tc, load_err
  );

  modport slave (
    input  clear, load, load_val, en, up,
    output count, tc, load_err
  );

endinterface

// File: rtl/bcd_digit_step.sv
// One combinational BCD digit step (increment or decrement).
//   digit_in  : current digit (assumed legal 0..9)
//   cin       : carry (up) or borrow (down) into this digit
//   up        : 1 = increment, 0 = decrement
//   digit_out : stepped digit
//   cout      : carry/borrow out to the next more significant digit
module bcd_digit_step
  import bcd_pkg::*;
(
  input  logic [3:0] digit_in,
  input  logic       cin,
  input  logic       up,
  output logic [3:0] digit_out,
  output logic       cout
);

  always_comb begin
    digit_out = digit_in;
    cout      = 1'b0;
    if (cin) begin
      if (up) begin
        if (digit_in == BCD_MAX) begin
          digit_out = BCD_ZERO;
          cout      = 1'b1;
        end else begin
          digit_out = digit_in + 4'd1;
        end
      end else begin
        if (digit_in == BCD_ZERO) begin
          digit_out = BCD_MAX;
          cout      = 1'b1;
        end else begin
          digit_out = digit_in - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit packed-BCD up/down counter with synchronous clear, validated
// parallel load and wrap/saturate terminal behaviour.
//   clk   : system clock, all state on rising edge
//   rst_n : synchronous active-low reset
//   bus   : slave side of bcd_updown_counter_if (commands in, count/tc/load_err out)
// Parameters: DIGITS (1..8) BCD digits; SATURATE 0 = wrap, 1 = hold at 0/max.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bcd_updown_counter_if.slave  bus
);

  localparam int W = BCD_W * DIGITS;

  logic [W-1:0]    count_q;
  logic            tc_q;
  logic            err_q;

  logic [W-1:0]    step_val;
  logic [DIGITS:0] chain;
  logic            load_ok;

  logic [W-1:0]    next_count;
  logic            next_tc;
  logic            next_err;

  // Digit 0 always steps; each further digit steps only on carry/borrow.
  assign chain[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_step u_step (
      .digit_in  (count_q[g*BCD_W +: BCD_W]),
      .cin       (chain[g]),
      .up        (bus.up),
      .digit_out (step_val[g*BCD_W +: BCD_W]),
      .cout      (chain[g+1])
    );
  end

  // A load is accepted only if every digit is legal, so count never holds
  // a non-BCD digit.
  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!bcd_digit_valid(bus.load_val[i*BCD_W +: BCD_W])) load_ok = 1'b0;
    end
  end

  // The carry out of the top digit is exactly the overflow/underflow
  // condition: it only propagates that far when every digit is at its
  // terminal value for the current direction.
  always_comb begin
    next_count = count_q;
    next_tc    = 1'b0;
    next_err   = 1'b0;
    if (bus.clear) begin
      next_count = '0;
    end else if (bus.load) begin
      if (load_ok) next_count = bus.load_val;
      else         next_err   = 1'b1;
    end else if (bus.en) begin
      next_tc = chain[DIGITS];
      if (chain[DIGITS] && SATURATE) next_count = count_q;
      else                           next_count = step_val;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= next_count;
      tc_q    <= next_tc;
      err_q   <= next_err;
    end
  end

  assign bus.count    = count_q;
  assign bus.tc       = tc_q;
  assign bus.load_err = err_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: a wrapping and a saturating 4-digit counter
// driven in lockstep, plus a 2-digit wrapping counter for the free-run case.
module tb_bcd_updown_counter;
  import bcd_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bcd_updown_counter_if #(.DIGITS(4)) bus_w ();
  bcd_updown_counter_if #(.DIGITS(4)) bus_s ();
  bcd_updown_counter_if #(.DIGITS(2)) bus_2 ();

  bcd_updown_counter #(.DIGITS(4), .SATURATE(1'b0)) u_wrap (.clk(clk), .rst_n(rst_n), .bus(bus_w));
  bcd_updown_counter #(.DIGITS(4), .SATURATE(1'b1)) u_sat  (.clk(clk), .rst_n(rst_n), .bus(bus_s));
  bcd_updown_counter #(.DIGITS(2), .SATURATE(1'b0)) u_d2   (.clk(clk), .rst_n(rst_n), .bus(bus_2));

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [35:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model (integer arithmetic) ----------------
  function automatic int bcd_to_int(input logic [31:0] v, input int digits);
    int n = 0;
    for (int i = digits - 1; i >= 0; i--) n = n * 10 + int'(v[i*4 +: 4]);
    return n;
  endfunction

  function automatic logic [31:0] int_to_bcd(input int n, input int digits);
    logic [31:0] r = '0;
    for (int i = 0; i < digits; i++) begin
      r[i*4 +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  function automatic bit all_digits_legal(input logic [31:0] v, input int digits);
    for (int i = 0; i < digits; i++) if (v[i*4 +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step(input int v, input bit up, input int digits, input bit sat,
                            output int nv, output bit tc);
    int maxv = 1;
    for (int i = 0; i < digits; i++) maxv = maxv * 10;
    maxv = maxv - 1;
    tc = 1'b0;
    if (up) begin
      if (v == maxv) begin tc = 1'b1; nv = sat ? v : 0; end
      else nv = v + 1;
    end else begin
      if (v == 0) begin tc = 1'b1; nv = sat ? 0 : maxv; end
      else nv = v - 1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive4(input logic c, input logic l, input logic [15:0] v,
                        input logic e, input logic u);
    bus_w.clear = c; bus_w.load = l; bus_w.load_val = v; bus_w.en = e; bus_w.up = u;
    bus_s.clear = c; bus_s.load = l; bus_s.load_val = v; bus_s.en = e; bus_s.up = u;
  endtask

  task automatic drive2(input logic c, input logic l, input logic [7:0] v,
                        input logic e, input logic u);
    bus_2.clear = c; bus_2.load = l; bus_2.load_val = v; bus_2.en = e; bus_2.up = u;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check4(input string tag, input logic [15:0] ew, input logic tw,
                        input logic [15:0] es, input logic ts, input logic err);
    check({tag, " wrap.count"}, 64'(bus_w.count), 64'(ew));
    check({tag, " wrap.tc"},    64'(bus_w.tc),    64'(tw));
    check({tag, " wrap.err"},   64'(bus_w.load_err), 64'(err));
    check({tag, " sat.count"},  64'(bus_s.count), 64'(es));
    check({tag, " sat.tc"},     64'(bus_s.tc),    64'(ts));
    check({tag, " sat.err"},    64'(bus_s.load_err), 64'(err));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        clear;
    logic        load;
    logic [15:0] load_val;
    logic        en;
    logic        up;
    logic [15:0] exp_w;
    logic        tc_w;
    logic [15:0] exp_s;
    logic        tc_s;
    logic        err;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input logic c, input logic l, input logic [15:0] v, input logic e,
                         input logic u, input logic [15:0] ew, input logic tw,
                         input logic [15:0] es, input logic ts, input logic err);
    vec_t x;
    x.clear = c; x.load = l; x.load_val = v; x.en = e; x.up = u;
    x.exp_w = ew; x.tc_w = tw; x.exp_s = es; x.tc_s = ts; x.err = err;
    vq.push_back(x);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int mw, ms, nw, ns;
    bit tw, ts;
    logic ew_err, es_err, ew_tc, es_tc;
    logic [35:0] e;
    logic [15:0] lv;
    logic r_c, r_l, r_e, r_u, r_rst;

    // Reset held for two edges while every command is asserted.
    rst_n = 1'b0;
    drive4(1'b0, 1'b1, 16'h1234, 1'b1, 1'b1);
    drive2(1'b0, 1'b1, 8'h12, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      check4("reset", 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
      check("reset d2.count", 64'(bus_2.count), 64'h0);
      check("reset d2.tc", 64'(bus_2.tc), 64'h0);
    end
    rst_n = 1'b1;
    drive2(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Glitch on rst_n between edges must not touch the count.
    drive4(1'b0, 1'b1, 16'h0005, 1'b0, 1'b0);
    tick();
    check4("preglitch", 16'h0005, 1'b0, 16'h0005, 1'b0, 1'b0);
    drive4(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    check4("glitch", 16'h0005, 1'b0, 16'h0005, 1'b0, 1'b0);

    //       clr  ld   val       en   up   exp_w    tw   exp_s    ts   err
    add_vec(1'b0,1'b1,16'h0999,1'b0,1'b0,16'h0999,1'b0,16'h0999,1'b0,1'b0);
    add_vec(1'b0,1'b0,16'h0000,1'b1,1'b1,16'h1000,1'b0,16'h1000,1'b0,1'b0);
    add_vec(1'b0,1'b1,16'h9999,1'b0,1'b0,16'h9999,1'b0,16'h9999,1'b0,1'b0);
    add_vec(1'b0,1'b0,16'h0000,1'b1,1'b1,16'h0000,1'b1,16'h9999,1'b1,1'b0);
    add_vec(1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000,1'b0,16'h9999,1'b0,1'b0);
    add_vec(1'b0,1'b1,16'h1000,1'b0,1'b0,16'h1000,1'b0,16'h1000,1'b0,1'b0);
    add_vec(1'b0,1'b0,16'h0000,1'b1,1'b0,16'h0999,1'b0,16'h0999,1'b0,1'b0);
    add_vec(1'b0,1'b1,16'h0000,1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0);
    add_vec(1'b0,1'b0,16'h0000,1'b1,1'b0,16'h9999,1'b1,16'h0000,1'b1,1'b0);
    add_vec(1'b0,1'b1,16'h12A4,1'b0,1'b0,16'h9999,1'b0,16'h0000,1'b0,1'b1);
    add_vec(1'b0,1'b0,16'h0000,1'b0,1'b0,16'h9999,1'b0,16'h0000,1'b0,1'b0);
    add_vec(1'b0,1'b1,16'h0009,1'b0,1'b0,16'h0009,1'b0,16'h0009,1'b0,1'b0);
    add_vec(1'b1,1'b1,16'h1234,1'b1,1'b1,16'h0000,1'b0,16'h0000,1'b0,1'b0);
    add_vec(1'b0,1'b1,16'h0042,1'b1,1'b1,16'h0042,1'b0,16'h0042,1'b0,1'b0);
    add_vec(1'b0,1'b0,16'h0000,1'b1,1'b1,16'h0043,1'b0,16'h0043,1'b0,1'b0);
    add_vec(1'b0,1'b1,16'h9999,1'b0,1'b0,16'h9999,1'b0,16'h9999,1'b0,1'b0);
    add_vec(1'b0,1'b0,16'h0000,1'b1,1'b1,16'h0000,1'b1,16'h9999,1'b1,1'b0);
    add_vec(1'b0,1'b1,16'hF000,1'b1,1'b1,16'h0000,1'b0,16'h9999,1'b0,1'b1);
    add_vec(1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0);
    add_vec(1'b0,1'b0,16'h0000,1'b1,1'b0,16'h9999,1'b1,16'h0000,1'b1,1'b0);

    foreach (vq[k]) begin
      drive4(vq[k].clear, vq[k].load, vq[k].load_val, vq[k].en, vq[k].up);
      tick();
      check4($sformatf("vec%0d", k), vq[k].exp_w, vq[k].tc_w, vq[k].exp_s, vq[k].tc_s, vq[k].err);
    end

    // Reset mid-sequence, then the first edge after release counts normally.
    drive4(1'b0, 1'b1, 16'h0777, 1'b0, 1'b0);
    tick();
    drive4(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    tick();
    check4("pre_rst", 16'h0778, 1'b0, 16'h0778, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    check4("mid_rst", 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    check4("post_rst", 16'h0001, 1'b0, 16'h0001, 1'b0, 1'b0);

    // Randomised run against the integer model.
    mw = 1;
    ms = 1;
    for (int i = 0; i < 400; i++) begin
      r_rst = ($urandom_range(0, 49) != 0);
      r_c   = ($urandom_range(0, 19) == 0);
      r_l   = ($urandom_range(0, 4) == 0);
      r_e   = ($urandom_range(0, 3) != 0);
      r_u   = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       lv = 16'($urandom);
        1:       lv = 16'h9999;
        2:       lv = 16'h0000;
        default: lv = 16'(int_to_bcd(int'($urandom_range(0, 9999)), 4));
      endcase
      ew_err = 1'b0; es_err = 1'b0; ew_tc = 1'b0; es_tc = 1'b0;
      if (!r_rst) begin
        mw = 0; ms = 0;
      end else if (r_c) begin
        mw = 0; ms = 0;
      end else if (r_l) begin
        if (all_digits_legal(32'(lv), 4)) begin
          mw = bcd_to_int(32'(lv), 4); ms = mw;
        end else begin
          ew_err = 1'b1; es_err = 1'b1;
        end
      end else if (r_e) begin
        model_step(mw, r_u, 4, 1'b0, nw, tw);
        model_step(ms, r_u, 4, 1'b1, ns, ts);
        mw = nw; ms = ns; ew_tc = tw; es_tc = ts;
      end
      exp_q.push_back({ew_err, ew_tc, 16'(int_to_bcd(mw, 4)),
                       es_err, es_tc, 16'(int_to_bcd(ms, 4))});
      rst_n = r_rst;
      drive4(r_c, r_l, lv, r_e, r_u);
      tick();
      e = exp_q.pop_front();
      check("rand wrap", 64'({bus_w.load_err, bus_w.tc, bus_w.count}), 64'(e[35:18]));
      check("rand sat",  64'({bus_s.load_err, bus_s.tc, bus_s.count}), 64'(e[17:0]));
    end
    rst_n = 1'b1;
    drive4(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

    // Two-digit free run from zero for 205 enabled cycles.
    drive2(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    check("d2 clear", 64'(bus_2.count), 64'h0);
    drive2(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 1; i <= 205; i++) begin
      tick();
      check($sformatf("d2 count@%0d", i), 64'(bus_2.count), 64'(int_to_bcd(i % 100, 2)));
      check($sformatf("d2 tc@%0d", i), 64'(bus_2.tc), 64'((i == 100) || (i == 200)));
      if (!all_digits_legal(32'(bus_2.count), 2)) begin
        n_fail++;
        $display("FAIL d2 digit@%0d: got %h required all digits <= 9", i, bus_2.count);
      end
    end
    check("d2 final", 64'(bus_2.count), 64'h05);
    drive2(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    check("d2 hold", 64'(bus_2.count), 64'h05);
    check("d2 tc idle", 64'(bus_2.tc), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
- Parametrised multi-digit BCD up/down counter with synchronous load, clear and wrap/saturate mode.
- Packed BCD count; digit 0 is least significant, in bits [3:0].
- Generalises the single-digit combinational BCD increment step to a registered DIGITS-wide counter with borrow, load validation and terminal-count signalling.
- Used as the timebase/event counter feeding 7-segment display drivers.

Parameters:
- DIGITS, 4, number of BCD digits; legal range 1..8.
- SATURATE, 0, 0 = wrap at 0/max, 1 = hold at 0/max.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
- clear  input  1  synchronous clear to all-zero.
- load  input  1  synchronous parallel load request.
- load_val  input  4*DIGITS  packed BCD value to load.
- en  input  1  count enable; one step per enabled cycle.
- up  input  1  1 = increment, 0 = decrement; sampled only when en=1.
- count  output  4*DIGITS  registered packed BCD count.
- tc  output  1  registered terminal-count pulse.
- load_err  output  1  registered pulse on a rejected load.

Behaviour:
- One clock and one reset: synchronous, active-low rst_n on clk; no asynchronous reset anywhere.
- Reset values:
  - count = 0.
  - tc = 0.
  - load_err = 0.
- Per-edge priority: rst_n=0 > clear > load > en. Lower-priority requests in the same cycle are ignored, with no pending or queued effect.
- clear: count <= 0; tc <= 0; load_err <= 0.
- load:
  - If every 4-bit digit of load_val is <= 9: count <= load_val; load_err <= 0.
  - If any digit is > 9: count is unchanged and load_err <= 1 for exactly one cycle.
  - tc <= 0 in both cases.
- en=1, up=1, per digit d:
  - If carry_in(d)=1 and digit=9: digit -> 0 and carry_out=1.
  - If carry_in(d)=1 and digit<9: digit+1 and carry_out=0.
  - Digit 0 has carry_in=1.
- en=1, up=0, per digit d:
  - If borrow_in(d)=1 and digit=0: digit -> 9 and borrow_out=1.
  - Otherwise: digit-1 and borrow_out=0.
- Carry/borrow ripple is combinational within one cycle. Latency from enabled edge to updated count is 1 cycle.
- Overflow and underflow:
  - Overflow: count = all-9s, en=1, up=1.
  - Underflow: count = 0, en=1, up=0.
  - SATURATE=0: count wraps (all-9s -> 0; 0 -> all-9s) and tc <= 1.
  - SATURATE=1: count holds and tc <= 1 on every such enabled cycle.
- tc is 0 in every other cycle, including en=0 cycles. It is registered and appears on the same edge that updates count.
- load_err is 0 except in the cycle after a rejected load.
- Illegal digits cannot enter count: only reset, clear, a validated load, or the BCD step write count.
- en=0 with no clear/load: count holds; tc <= 0; load_err <= 0.
- Reset mid-sequence discards any in-progress count. The first edge after rst_n returns high honours clear/load/en normally.
- Width arithmetic is per 4-bit digit only. There is no binary add across digit boundaries.

Decomposition:
- Shared package bcd_pkg holds:
  - BCD_W = 4.
  - BCD_MAX = 4'd9.
  - BCD_ZERO = 4'd0.
  - Function bcd_digit_valid(4-bit) -> 1-bit (digit <= 9).
- One natural sub-module, bcd_digit_step:
  - Combinational; ports digit_in[3:0], cin, up, digit_out[3:0], cout.
  - Instantiated DIGITS times in a generate loop, cout chained to the next digit's cin.
- Top level owns:
  - the count register;
  - priority logic;
  - load validation;
  - the saturate mux (selects the held count when the last digit's cout=1 and SATURATE=1);
  - the tc/load_err registers.

Test Plan:
- Reset: rst_n=0 for 2 cycles with en=1, load=1, load_val=16'h1234 -> count=16'h0000, tc=0, load_err=0 throughout. Asynchronous glitch of rst_n between edges -> no effect.
- Up ripple, DIGITS=4: load 16'h0999, then en=1, up=1 for 1 cycle -> count=16'h1000, tc=0. Load 16'h9999, step up -> SATURATE=0: count=16'h0000, tc=1 for 1 cycle. SATURATE=1: count=16'h9999, tc=1.
- Down borrow: load 16'h1000, en=1, up=0 -> count=16'h0999. Then load 16'h0000 and step down -> SATURATE=0: 16'h9999 with tc=1. SATURATE=1: 16'h0000 with tc=1.
- Load validation: load_val=16'h12A4 -> count unchanged, load_err=1 for exactly 1 cycle then 0. load_val=16'h0009 -> count=16'h0009, load_err=0.
- Priority: clear=1, load=1, en=1 same edge -> count=0. load=1 with en=1, load_val=16'h0042 -> count=16'h0042, not 16'h0043.
- Free-run: DIGITS=2, en=1, up=1 from 0 for 205 cycles -> count cycles 00..99 in BCD only, never shows a digit > 9, tc pulses exactly at cycles 100 and 200, final count=8'h05.
